// File: rtl/ili9341_link_arbiter.sv
// Two-port arbiter sharing one ILI9341 serial link (cs/dc/din). Grants per burst and
// shifts each word MSB-first; all state moves on the falling edge so the panel samples on the rise.
module ili9341_link_arbiter #(
    parameter int unsigned CS_GAP     = 1,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_dc,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_len,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_dc,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_len,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic        grant,
    output logic        busy,
    output logic        cs,
    output logic        dc,
    output logic        din
);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

    localparam logic [3:0] GapLast = 4'(CS_GAP - 1);

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        rr_q, rr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  gap_q, gap_d;
    logic [31:0] data_q, data_d;
    logic        last_q, last_d;
    logic        cs_q, cs_d;
    logic        dc_q, dc_d;
    logic        din_q, din_d;

    logic        sel_valid, sel_dc, sel_last;
    logic [31:0] sel_data;
    logic [4:0]  sel_len;

    always_comb begin
        sel_valid = grant_q ? req1_valid : req0_valid;
        sel_dc    = grant_q ? req1_dc    : req0_dc;
        sel_data  = grant_q ? req1_data  : req0_data;
        sel_len   = grant_q ? req1_len   : req0_len;
        sel_last  = grant_q ? req1_last  : req0_last;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        data_d  = data_q;
        last_d  = last_q;
        cs_d    = cs_q;
        dc_d    = dc_q;
        din_d   = din_q;
        unique case (state_q)
            StIdle: begin
                cs_d = 1'b1;
                if (req0_valid || req1_valid) begin
                    state_d = StLoad;
                    if (req0_valid && req1_valid) begin
                        grant_d = (FIXED_PRIO != 0) ? 1'b0 : rr_q;
                    end else begin
                        grant_d = req1_valid;
                    end
                end
            end
            StLoad: begin
                if (sel_valid) begin
                    data_d  = sel_data;
                    last_d  = sel_last;
                    cnt_d   = sel_len;
                    cs_d    = 1'b0;
                    dc_d    = sel_dc;
                    din_d   = sel_data[sel_len];
                    state_d = StShift;
                end else begin
                    // Requester withdrew: treat as end of burst so the other port gets a turn.
                    state_d = StGap;
                    gap_d   = '0;
                    rr_d    = ~grant_q;
                end
            end
            StShift: begin
                if (cnt_q == 5'd0) begin
                    cs_d = 1'b1;
                    if (last_q) begin
                        state_d = StGap;
                        gap_d   = '0;
                        rr_d    = ~grant_q;
                    end else begin
                        state_d = StLoad;
                    end
                end else begin
                    cnt_d = cnt_q - 5'd1;
                    din_d = data_q[cnt_q - 5'd1];
                end
            end
            StGap: begin
                cs_d = 1'b1;
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cs_q    <= 1'b1;
            dc_q    <= 1'b0;
            din_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cs_q    <= cs_d;
            dc_q    <= dc_d;
            din_q   <= din_d;
        end
    end

    assign req0_ready = (state_q == StLoad) && !grant_q;
    assign req1_ready = (state_q == StLoad) && grant_q;
    assign grant      = grant_q;
    assign busy       = (state_q != StIdle);
    assign cs         = cs_q;
    assign dc         = dc_q;
    assign din        = din_q;

endmodule

// File: tb/tb_ili9341_link_arbiter.sv
// Directed bench: two DUTs (round-robin/CS_GAP=1 and fixed-priority/CS_GAP=3) on shared stimulus;
// a posedge monitor reassembles each cs-low run into a word record.
module tb_ili9341_link_arbiter;

    logic        clk = 1'b1;
    logic        rst;
    logic        req0_valid, req0_dc, req0_last;
    logic [31:0] req0_data;
    logic [4:0]  req0_len;
    logic        req1_valid, req1_dc, req1_last;
    logic [31:0] req1_data;
    logic [4:0]  req1_len;

    logic r0_a, r1_a, g_a, busy_a, cs_a, dc_a, din_a;
    logic r0_b, r1_b, g_b, busy_b, cs_b, dc_b, din_b;
    logic sel_fp = 1'b0;

    logic m_r0, m_r1, m_g, m_busy, m_cs, m_dc, m_din;
    assign m_r0   = sel_fp ? r0_b   : r0_a;
    assign m_r1   = sel_fp ? r1_b   : r1_a;
    assign m_g    = sel_fp ? g_b    : g_a;
    assign m_busy = sel_fp ? busy_b : busy_a;
    assign m_cs   = sel_fp ? cs_b   : cs_a;
    assign m_dc   = sel_fp ? dc_b   : dc_a;
    assign m_din  = sel_fp ? din_b  : din_a;

    always #5 clk = ~clk;

    ili9341_link_arbiter #(.CS_GAP(1), .FIXED_PRIO(0)) u_dut_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_dc(req0_dc), .req0_data(req0_data),
        .req0_len(req0_len), .req0_last(req0_last), .req0_ready(r0_a),
        .req1_valid(req1_valid), .req1_dc(req1_dc), .req1_data(req1_data),
        .req1_len(req1_len), .req1_last(req1_last), .req1_ready(r1_a),
        .grant(g_a), .busy(busy_a), .cs(cs_a), .dc(dc_a), .din(din_a)
    );

    ili9341_link_arbiter #(.CS_GAP(3), .FIXED_PRIO(1)) u_dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_dc(req0_dc), .req0_data(req0_data),
        .req0_len(req0_len), .req0_last(req0_last), .req0_ready(r0_b),
        .req1_valid(req1_valid), .req1_dc(req1_dc), .req1_data(req1_data),
        .req1_len(req1_len), .req1_last(req1_last), .req1_ready(r1_b),
        .grant(g_b), .busy(busy_b), .cs(cs_b), .dc(dc_b), .din(din_b)
    );

    typedef struct {
        int          n;
        logic [31:0] v;
        logic        dc;
        logic        dc_ok;
        logic        g;
        int          hi;
    } word_t;

    word_t       wq[$];
    int          mon_n, mon_hi, mon_start_hi;
    logic [31:0] mon_val;
    logic        mon_dc0, mon_dcok, mon_g;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word monitor: the panel samples din/dc on the rising edge while cs is low.
    initial begin
        mon_n = 0;
        mon_hi = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                mon_n  = 0;
                mon_hi = 0;
            end else if (!m_cs) begin
                if (mon_n == 0) begin
                    mon_val      = '0;
                    mon_start_hi = mon_hi;
                    mon_dc0      = m_dc;
                    mon_dcok     = 1'b1;
                end
                if (m_dc !== mon_dc0) mon_dcok = 1'b0;
                mon_val = {mon_val[30:0], m_din};
                mon_n++;
                mon_g  = m_g;
                mon_hi = 0;
            end else begin
                if (mon_n != 0) wq.push_back('{mon_n, mon_val, mon_dc0, mon_dcok, mon_g, mon_start_hi});
                mon_n = 0;
                mon_hi++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int p, input logic v, input logic d, input logic [31:0] w,
                         input logic [4:0] l, input logic lst);
        if (p == 0) begin
            req0_valid = v; req0_dc = d; req0_data = w; req0_len = l; req0_last = lst;
        end else begin
            req1_valid = v; req1_dc = d; req1_data = w; req1_len = l; req1_last = lst;
        end
    endtask

    task automatic put_word(input string tag, input int p, input logic d, input logic [31:0] w,
                            input logic [4:0] l, input logic lst);
        bit ok = 1'b0;
        drive(p, 1'b1, d, w, l, lst);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if ((p == 0) ? m_r0 : m_r1) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, ".ready"}, 64'(ok), 64'd1);
        @(negedge clk);
        #1;
        drive(p, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (!m_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, ".idle"}, 64'(ok), 64'd1);
    endtask

    // Counts busy cycles with cs high after the current word ends.
    task automatic check_gap(input string tag, input int exp);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (m_cs) break;
        end
        for (int i = 0; i < 100; i++) begin
            if (!m_busy) break;
            n++;
            @(posedge clk);
        end
        check_eq({tag, ".gap"}, 64'(n), 64'(exp));
    endtask

    task automatic check_word(input string tag, input int idx, input int nbits,
                              input logic [31:0] val, input logic wdc, input logic g, input int hi);
        check_eq({tag, ".present"}, 64'(wq.size() > idx), 64'd1);
        if (wq.size() > idx) begin
            check_eq({tag, ".bits"}, 64'(wq[idx].n), 64'(nbits));
            check_eq({tag, ".data"}, 64'(wq[idx].v), 64'(val));
            check_eq({tag, ".dc"}, 64'({wq[idx].dc, wq[idx].dc_ok}), 64'({wdc, 1'b1}));
            check_eq({tag, ".grant"}, 64'(wq[idx].g), 64'(g));
            if (hi >= 0) check_eq({tag, ".cs_hi"}, 64'(wq[idx].hi), 64'(hi));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wq.delete();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            check_eq("rst_idle", 64'({m_cs, m_dc, m_din, m_busy, m_r0, m_r1}), 64'(6'b100000));
        end

        // Single command byte 0x2A
        wq.delete();
        put_word("cmd2a", 0, 1'b0, 32'h2A, 5'd7, 1'b1);
        check_gap("cmd2a", 1);
        check_word("cmd2a", 0, 8, 32'h2A, 1'b0, 1'b0, -1);

        // Two-word burst on port 0 while port 1 waits
        wq.delete();
        fork
            begin
                put_word("burst.w0", 0, 1'b0, 32'h2B, 5'd7, 1'b0);
                put_word("burst.w1", 0, 1'b1, 32'h003C0103, 5'd31, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                put_word("burst.p1", 1, 1'b1, 32'h55, 5'd7, 1'b1);
            end
        join
        wait_idle("burst");
        check_word("burst.w0", 0, 8, 32'h2B, 1'b0, 1'b0, -1);
        check_word("burst.w1", 1, 32, 32'h003C0103, 1'b1, 1'b0, 1);
        check_word("burst.p1", 2, 8, 32'h55, 1'b1, 1'b1, 3);

        // Round-robin under continuous contention
        wq.delete();
        fork
            begin
                put_word("rr.a0", 0, 1'b1, 32'hA0, 5'd7, 1'b1);
                put_word("rr.a1", 0, 1'b1, 32'hA1, 5'd7, 1'b1);
            end
            begin
                put_word("rr.b0", 1, 1'b1, 32'hB0, 5'd7, 1'b1);
                put_word("rr.b1", 1, 1'b1, 32'hB1, 5'd7, 1'b1);
            end
        join
        wait_idle("rr");
        check_word("rr.0", 0, 8, 32'hA0, 1'b1, 1'b0, -1);
        check_word("rr.1", 1, 8, 32'hB0, 1'b1, 1'b1, 3);
        check_word("rr.2", 2, 8, 32'hA1, 1'b1, 1'b0, 3);
        check_word("rr.3", 3, 8, 32'hB1, 1'b1, 1'b1, 3);

        // RGB565 red pixel on port 1
        wq.delete();
        put_word("rgb", 1, 1'b1, 32'hF800, 5'd15, 1'b1);
        wait_idle("rgb");
        check_word("rgb", 0, 16, 32'hF800, 1'b1, 1'b1, -1);

        // Reset after the 6th bit of a pixel
        wq.delete();
        put_word("rgb_rst", 1, 1'b1, 32'hF800, 5'd15, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check_eq("rgb_rst.partial", 64'({mon_n[7:0], mon_val[5:0]}), 64'({8'd6, 6'b111110}));
        rst = 1'b1;
        #1;
        check_eq("rgb_rst.async", 64'({m_cs, m_busy, m_r0, m_r1}), 64'(4'b1000));
        @(posedge clk);
        #1 rst = 1'b0;
        wq.delete();
        put_word("restart", 0, 1'b0, 32'h2A, 5'd7, 1'b1);
        wait_idle("restart");
        check_word("restart", 0, 8, 32'h2A, 1'b0, 1'b0, -1);
        check_eq("restart.count", 64'(wq.size()), 64'd1);

        // Abort in LOAD moves the round-robin pointer to port 1
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 32'h77;
        req0_len   = 5'd7;
        req0_last  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (m_r0) break;
        end
        check_eq("abort.ready", 64'(m_r0), 64'd1);
        req0_valid = 1'b0;
        wait_idle("abort");
        check_eq("abort.no_word", 64'({wq.size(), mon_n}), 64'd0);
        fork
            put_word("abort.p0", 0, 1'b0, 32'hC0, 5'd7, 1'b1);
            put_word("abort.p1", 1, 1'b0, 32'hC1, 5'd7, 1'b1);
        join
        wait_idle("abort.after");
        check_word("abort.first", 0, 8, 32'hC1, 1'b0, 1'b1, -1);
        check_word("abort.second", 1, 8, 32'hC0, 1'b0, 1'b0, 3);

        // Fixed priority, CS_GAP=3
        sel_fp = 1'b1;
        do_reset();
        @(posedge clk);
        check_eq("fp.rst", 64'({m_cs, m_dc, m_din, m_busy, m_r0, m_r1}), 64'(6'b100000));
        fork
            begin
                put_word("fp.a0", 0, 1'b0, 32'hD0, 5'd7, 1'b1);
                put_word("fp.a1", 0, 1'b0, 32'hD1, 5'd7, 1'b1);
            end
            put_word("fp.b0", 1, 1'b1, 32'hE0, 5'd7, 1'b1);
        join
        wait_idle("fp");
        check_word("fp.0", 0, 8, 32'hD0, 1'b0, 1'b0, -1);
        check_word("fp.1", 1, 8, 32'hD1, 1'b0, 1'b0, 5);
        check_word("fp.2", 2, 8, 32'hE0, 1'b1, 1'b1, 5);
        wq.delete();
        put_word("fp.len0", 1, 1'b1, 32'h1, 5'd0, 1'b1);
        check_gap("fp.len0", 3);
        check_word("fp.len0", 0, 1, 32'h1, 1'b1, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
